// File: rtl/flick_conditioner.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | flick_conditioner: synchronises, debounces and counts a flick button.  |
// | Optional auto-repeat while held: define FLICK_AUTOREPEAT_EN.           |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module flick_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned REPEAT_CYCLES   = 1024
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_in,
   output logic       flk,
   output logic       flk_pulse,
   output logic [7:0] press_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_DEB_PRESS = 2'd1,
      ST_PRESSED   = 2'd2,
      ST_DEB_REL   = 2'd3
   } state_t;

   localparam logic [15:0] c_deb_last = 16'(DEBOUNCE_CYCLES - 1);

   logic        sync1_q;
   logic        btn_s_q;
   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] cnt_inc;
   logic        flk_q, flk_d;
   logic        pulse_q, pulse_d;
   logic [7:0]  press_cnt_q, press_cnt_d;
   logic        rpt_fire;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= 1'b0;
         btn_s_q <= 1'b0;
      end else begin
         sync1_q <= btn_in;
         btn_s_q <= sync1_q;
      end
   end

`ifdef FLICK_AUTOREPEAT_EN
   localparam logic [15:0] c_rpt_period = 16'(REPEAT_CYCLES);

   logic [15:0] rpt_q, rpt_d;

   assign rpt_fire = (state_q == ST_PRESSED) && btn_s_q && ((rpt_q + 16'd1) == c_rpt_period);

   // Restart the repeat period on a fresh press; hold it across release bounces.
   always_comb begin
      rpt_d = rpt_q;
      if ((state_q == ST_DEB_PRESS) && (state_d == ST_PRESSED)) begin
         rpt_d = '0;
      end else if ((state_q == ST_PRESSED) && btn_s_q) begin
         rpt_d = rpt_fire ? 16'd0 : (rpt_q + 16'd1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rpt_q <= '0;
      end else begin
         rpt_q <= rpt_d;
      end
   end
`else
   assign rpt_fire = 1'b0;
`endif

   // The IDLE->DEB_PRESS sample is the first stable one, so the DEB states
   // finish when the incremented count reaches DEBOUNCE_CYCLES-1.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cnt_inc     = cnt_q + 16'd1;
      pulse_d     = 1'b0;
      press_cnt_d = press_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (btn_s_q) begin
               state_d = ST_DEB_PRESS;
               cnt_d   = '0;
            end
         end
         ST_DEB_PRESS: begin
            if (!btn_s_q) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_inc == c_deb_last) begin
               state_d = ST_PRESSED;
               cnt_d   = '0;
               pulse_d = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_PRESSED: begin
            if (!btn_s_q) begin
               state_d = ST_DEB_REL;
               cnt_d   = '0;
            end else if (rpt_fire) begin
               pulse_d = 1'b1;
            end
         end
         ST_DEB_REL: begin
            if (btn_s_q) begin
               state_d = ST_PRESSED;
               cnt_d   = '0;
            end else if (cnt_inc == c_deb_last) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
      if (pulse_d) begin
         press_cnt_d = press_cnt_q + 8'd1;
      end
      flk_d = (state_d == ST_PRESSED) || (state_d == ST_DEB_REL);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         flk_q       <= 1'b0;
         pulse_q     <= 1'b0;
         press_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         flk_q       <= flk_d;
         pulse_q     <= pulse_d;
         press_cnt_q <= press_cnt_d;
      end
   end

   assign flk       = flk_q;
   assign flk_pulse = pulse_q;
   assign press_cnt = press_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_flick_conditioner.sv
`default_nettype none
// Directed bench for flick_conditioner with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
module tb_flick_conditioner;

`ifdef FLICK_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       btn_in = 1'b0;
   logic       flk;
   logic       flk_pulse;
   logic [7:0] press_cnt;

   int n_vec = 0;
   int n_err = 0;
   int pulse_seen = 0;
   logic prev_pulse = 1'b0;

   flick_conditioner #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_in    (btn_in),
      .flk       (flk),
      .flk_pulse (flk_pulse),
      .press_cnt (press_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse tally and back-to-back pulse detection, sampled mid-cycle.
   always @(negedge clk) begin
      if (flk_pulse) begin
         pulse_seen++;
         n_vec++;
         assert (prev_pulse === 1'b0) else begin
            n_err++;
            $error("FAIL pulse_adjacent: observed %0b expected %0b", prev_pulse, 1'b0);
         end
      end
      prev_pulse = flk_pulse;
   end

   initial begin
      int base;
      // Reset state
      repeat (3) tick();
      check("rst_flk", flk, 0);
      check("rst_pulse", flk_pulse, 0);
      check("rst_cnt", press_cnt, 0);
      rst = 1'b1;
      repeat (3) tick();

      // Clean press: rise on the 6th edge, held 10 cycles, then released
      btn_in = 1'b1;
      repeat (5) tick();
      check("clean_pre_flk", flk, 0);
      tick();
      check("clean_flk", flk, 1);
      check("clean_pulse", flk_pulse, 1);
      check("clean_cnt", press_cnt, 1);
      tick();
      check("clean_pulse_off", flk_pulse, 0);
      repeat (3) tick();
      btn_in = 1'b0;
      repeat (5) tick();
      check("rel_pre_flk", flk, 1);
      tick();
      check("rel_flk", flk, 0);
      check("rel_pulse", flk_pulse, 0);
      check("rel_cnt", press_cnt, 1);
      repeat (3) tick();
      check("clean_pulses", pulse_seen, 1);

      // Bounce 1,0,1,0 then steady high
      btn_in = 1'b1; tick();
      btn_in = 1'b0; tick();
      btn_in = 1'b1; tick();
      btn_in = 1'b0; tick();
      btn_in = 1'b1;
      repeat (5) tick();
      check("bounce_pre_flk", flk, 0);
      check("bounce_pre_cnt", press_cnt, 1);
      tick();
      check("bounce_flk", flk, 1);
      check("bounce_pulse", flk_pulse, 1);
      check("bounce_cnt", press_cnt, 2);
      tick();

      // Release bounce: low for 2 cycles while pressed
      btn_in = 1'b0; repeat (2) tick();
      btn_in = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("relb_flk", flk, 1);
         check("relb_pulse", flk_pulse, 0);
      end
      check("relb_cnt", press_cnt, 2);
      btn_in = 1'b0;
      repeat (6) tick();
      check("relb_done_flk", flk, 0);
      repeat (3) tick();

      // Glitch of 3 samples is rejected
      btn_in = 1'b1; repeat (3) tick();
      btn_in = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         check("glitch_flk", flk, 0);
      end
      check("glitch_cnt", press_cnt, 2);
      check("glitch_pulses", pulse_seen, 2);

      // Exactly 4 samples high is accepted
      btn_in = 1'b1; repeat (4) tick();
      btn_in = 1'b0; repeat (2) tick();
      check("edge4_flk", flk, 1);
      check("edge4_pulse", flk_pulse, 1);
      check("edge4_cnt", press_cnt, 3);
      repeat (6) tick();
      check("edge4_rel_flk", flk, 0);
      repeat (2) tick();

      // Wrap: 253 more presses brings the count to 256 -> 0
      for (int p = 0; p < 253; p++) begin
         btn_in = 1'b1; repeat (6) tick();
         btn_in = 1'b0; repeat (8) tick();
         if (p == 251) check("wrap_255", press_cnt, 255);
      end
      check("wrap_cnt", press_cnt, 0);
      check("wrap_pulses", pulse_seen, 256);

      // One press so reset has a nonzero count to clear
      btn_in = 1'b1; repeat (6) tick();
      btn_in = 1'b0; repeat (8) tick();
      check("pre_rst_cnt", press_cnt, 1);

      // Async reset mid DEB_PRESS, between edges
      btn_in = 1'b1; repeat (4) tick();
      #2 rst = 1'b0;
      #1;
      check("arst_flk", flk, 0);
      check("arst_pulse", flk_pulse, 0);
      check("arst_cnt", press_cnt, 0);
      tick();
      #2 rst = 1'b1;
      repeat (5) tick();
      check("arst_pre_flk", flk, 0);
      check("arst_pulses", pulse_seen, 257);
      tick();
      check("arst_flk_rise", flk, 1);
      check("arst_pulse_rise", flk_pulse, 1);
      check("arst_cnt_rise", press_cnt, 1);

      // Long hold: repeat pulses at +8, +16, +24 only with auto-repeat
      base = pulse_seen;
      for (int k = 1; k <= 24; k++) begin
         tick();
         check("hold_pulse", flk_pulse, (AR && (k % 8 == 0)) ? 1 : 0);
      end
      check("hold_cnt", press_cnt, AR ? 4 : 1);
      repeat (2) tick();
      btn_in = 1'b0;
      repeat (10) tick();
      check("hold_rel_flk", flk, 0);
      check("hold_rel_cnt", press_cnt, AR ? 4 : 1);
      check("hold_pulses", pulse_seen - base, AR ? 4 : 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
